// File: rtl/accum_writeback.sv
// accum_writeback: read-modify-write accumulator between a systolic array and an
// accumulation buffer with a fixed-latency read port and a single write port.
`default_nettype none

module accum_writeback #(
  parameter int ACC_WIDTH       = 16,
  parameter int NUM_OC          = 4,
  parameter int BANK_ADDR_WIDTH = 32,
  parameter int READ_LATENCY    = 2,
  localparam int DATA_WIDTH     = ACC_WIDTH * NUM_OC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_first,
  input  logic                       in_last,
  input  logic [BANK_ADDR_WIDTH-1:0] in_adr,
  input  logic [DATA_WIDTH-1:0]      in_psum,
  output logic                       ren_sys_arr,
  output logic [BANK_ADDR_WIDTH-1:0] radr_sys_arr,
  input  logic [DATA_WIDTH-1:0]      rdata_sys_arr,
  output logic                       wen,
  output logic [BANK_ADDR_WIDTH-1:0] wadr,
  output logic [DATA_WIDTH-1:0]      wdata,
  output logic                       busy,
  output logic                       tile_done
);

  localparam int RL = READ_LATENCY;

  logic [RL-1:0]              vld_q;
  logic [RL-1:0]              first_q;
  logic [RL-1:0]              last_q;
  logic [BANK_ADDR_WIDTH-1:0] adr_q  [RL];
  logic [DATA_WIDTH-1:0]      psum_q [RL];

  logic                       wr_vld_q;
  logic                       wr_last_q;
  logic [BANK_ADDR_WIDTH-1:0] wr_adr_q;
  logic [DATA_WIDTH-1:0]      wr_data_q;
  logic [DATA_WIDTH-1:0]      wr_data_d;

  logic hit;
  logic accept;

  // A word that reads the buffer must not overtake a pending write to the same address.
  always_comb begin
    hit = wr_vld_q && (wr_adr_q == in_adr);
    for (int i = 0; i < RL; i++) begin
      if (vld_q[i] && (adr_q[i] == in_adr)) begin
        hit = 1'b1;
      end
    end
  end

  assign in_ready     = !rst && !(in_valid && !in_first && hit);
  assign accept       = in_valid && in_ready;
  assign ren_sys_arr  = accept && !in_first;
  assign radr_sys_arr = in_adr;

  for (genvar k = 0; k < NUM_OC; k++) begin : g_lane
    logic [ACC_WIDTH-1:0] old_lane;
    assign old_lane = first_q[RL-1] ? '0 : rdata_sys_arr[k*ACC_WIDTH +: ACC_WIDTH];
    assign wr_data_d[k*ACC_WIDTH +: ACC_WIDTH] =
        old_lane + psum_q[RL-1][k*ACC_WIDTH +: ACC_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= '0;
      first_q   <= '0;
      last_q    <= '0;
      wr_vld_q  <= 1'b0;
      wr_last_q <= 1'b0;
      wr_adr_q  <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < RL; i++) begin
        adr_q[i]  <= '0;
        psum_q[i] <= '0;
      end
    end else begin
      vld_q[0]   <= accept;
      first_q[0] <= in_first;
      last_q[0]  <= in_last;
      adr_q[0]   <= in_adr;
      psum_q[0]  <= in_psum;
      for (int i = 1; i < RL; i++) begin
        vld_q[i]   <= vld_q[i-1];
        first_q[i] <= first_q[i-1];
        last_q[i]  <= last_q[i-1];
        adr_q[i]   <= adr_q[i-1];
        psum_q[i]  <= psum_q[i-1];
      end
      wr_vld_q  <= vld_q[RL-1];
      wr_last_q <= vld_q[RL-1] && last_q[RL-1];
      wr_adr_q  <= adr_q[RL-1];
      wr_data_q <= wr_data_d;
    end
  end

  assign wen       = wr_vld_q;
  assign wadr      = wr_adr_q;
  assign wdata     = wr_data_q;
  assign tile_done = wr_vld_q && wr_last_q;
  assign busy      = (|vld_q) || wr_vld_q;

endmodule

`default_nettype wire

// File: tb/tb_accum_writeback.sv
// tb_accum_writeback: scoreboard bench for accum_writeback with a behavioural
// fixed-latency accumulation buffer.
`default_nettype none

module tb_accum_writeback;

  localparam int ACC = 16;
  localparam int NOC = 4;
  localparam int AW  = 32;
  localparam int RL  = 2;
  localparam int DW  = ACC * NOC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_first = 1'b0;
  logic          in_last = 1'b0;
  logic [AW-1:0] in_adr = '0;
  logic [DW-1:0] in_psum = '0;
  logic          ren_sys_arr;
  logic [AW-1:0] radr_sys_arr;
  logic [DW-1:0] rdata_sys_arr;
  logic          wen;
  logic [AW-1:0] wadr;
  logic [DW-1:0] wdata;
  logic          busy;
  logic          tile_done;

  accum_writeback #(
    .ACC_WIDTH(ACC), .NUM_OC(NOC), .BANK_ADDR_WIDTH(AW), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
    .in_adr(in_adr), .in_psum(in_psum),
    .ren_sys_arr(ren_sys_arr), .radr_sys_arr(radr_sys_arr), .rdata_sys_arr(rdata_sys_arr),
    .wen(wen), .wadr(wadr), .wdata(wdata), .busy(busy), .tile_done(tile_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] adr;
    logic [DW-1:0] data;
    logic          last;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] buf_mem [256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] rd_pipe [RL];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] accum(input logic [DW-1:0] old, input logic [DW-1:0] ps,
                                          input logic first);
    logic [DW-1:0] r;
    for (int k = 0; k < NOC; k++) begin
      r[k*ACC +: ACC] = (first ? 16'h0 : old[k*ACC +: ACC]) + ps[k*ACC +: ACC];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] lanes(input int l0, input int l1, input int l2, input int l3);
    logic [DW-1:0] r;
    r[0*ACC +: ACC] = l0[ACC-1:0];
    r[1*ACC +: ACC] = l1[ACC-1:0];
    r[2*ACC +: ACC] = l2[ACC-1:0];
    r[3*ACC +: ACC] = l3[ACC-1:0];
    return r;
  endfunction

  // Buffer model: write on wen, read data appears RL cycles after ren.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wen) buf_mem[wadr[7:0]] <= wdata;
    rd_pipe[0] <= ren_sys_arr ? buf_mem[radr_sys_arr[7:0]] : 'x;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign rdata_sys_arr = rd_pipe[RL-1];

  always @(negedge clk) begin
    if (!rst) begin
      if (wen) begin
        if (sb.size() == 0) begin
          check("spurious_wen", wen, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("wadr", wadr, e.adr);
          check("wdata", wdata, e.data);
          check("tile_done_on_wen", tile_done, e.last);
          check("wr_latency", cyc - e.cyc, RL + 1);
        end
      end else begin
        check("tile_done_idle", tile_done, 1'b0);
      end
    end
  end

  // Offer a word from the next negedge; returns #1 after the negedge of the accept cycle.
  task automatic send(input int adr, input logic [DW-1:0] ps, input logic first,
                      input logic last, output int acc);
    exp_t e;
    int   waited;
    @(negedge clk);
    in_valid = 1'b1;
    in_adr   = adr;
    in_psum  = ps;
    in_first = first;
    in_last  = last;
    #1;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) check("accept_timeout", in_ready, 1'b1);
    e.adr  = adr;
    e.data = accum(ref_mem[adr[7:0]], ps, first);
    e.last = last;
    e.cyc  = cyc;
    ref_mem[adr[7:0]] = e.data;
    sb.push_back(e);
    acc = cyc;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 100) begin
      idle_cycle();
      n++;
    end
    check("drain_queue", sb.size(), 0);
  endtask

  initial begin
    int            t;
    logic [DW-1:0] saved;
    logic [DW-1:0] v;

    for (int i = 0; i < 256; i++) begin
      v = {$urandom(), $urandom()};
      buf_mem[i] = v;
      ref_mem[i] = v;
    end
    buf_mem[7] = lanes(10, 20, 30, 40);
    ref_mem[7] = lanes(10, 20, 30, 40);
    buf_mem[8] = lanes('h7FFF, 'hFFFF, 0, 'h8000);
    ref_mem[8] = lanes('h7FFF, 'hFFFF, 0, 'h8000);

    in_valid = 1'b1;
    #1;
    check("rst_wen", wen, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_ren", ren_sys_arr, 1'b0);
    check("rst_tile_done", tile_done, 1'b0);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // First word: nothing read from the buffer.
    send(5, lanes(1, 2, 3, 4), 1'b1, 1'b0, t);
    check("first_ren", ren_sys_arr, 1'b0);
    idle_cycle();
    wait_drain();
    check("first_result", buf_mem[5], lanes(1, 2, 3, 4));

    // Accumulate onto stored value; then RAW stall on the same address.
    send(7, lanes(1, 1, 1, 1), 1'b0, 1'b0, t);
    check("acc_ren", ren_sys_arr, 1'b1);
    check("acc_radr", radr_sys_arr, 7);
    @(negedge clk);
    in_psum = lanes(2, 2, 2, 2);
    #1;
    check("raw_stall_c1", in_ready, 1'b0);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      #1;
      check("raw_stall", in_ready, (i == 4));
    end
    begin
      exp_t e;
      e.adr  = 7;
      e.data = accum(ref_mem[7], lanes(2, 2, 2, 2), 1'b0);
      e.last = 1'b0;
      e.cyc  = cyc;
      ref_mem[7] = e.data;
      sb.push_back(e);
    end
    check("raw_accept_cycle", cyc - t, 4);
    idle_cycle();
    wait_drain();
    check("acc_11_21_31_41_plus2", buf_mem[7], lanes(13, 23, 33, 43));

    // Lane wrap, no inter-lane carry.
    send(8, lanes(1, 2, 0, 'hFFFF), 1'b0, 1'b0, t);
    idle_cycle();
    wait_drain();
    check("wrap_result", buf_mem[8], lanes('h8000, 'h0001, 0, 'h7FFF));

    // Tile-done pulse and busy window for a lone last word.
    send(10, lanes(9, 8, 7, 6), 1'b1, 1'b1, t);
    for (int i = 1; i <= 4; i++) begin
      idle_cycle();
      check("busy_window", busy, (i <= 3));
      check("tile_done_pulse", tile_done, (i == 3));
    end

    // Random stream over a small address set to mix hazards and back-to-back accepts.
    for (int n = 0; n < 60; n++) begin
      send(20 + $urandom_range(0, 3), {$urandom(), $urandom()},
           ($urandom_range(0, 3) == 0), (n == 59), t);
    end
    idle_cycle();
    wait_drain();

    // Distinct addresses must stream one per cycle.
    send(40, lanes(1, 1, 1, 1), 1'b0, 1'b0, t);
    saved = '0;
    for (int n = 1; n < 6; n++) begin
      int t2;
      send(40 + n, lanes(n, n, n, n), 1'b0, 1'b0, t2);
      check("stream_rate", t2 - t, n);
    end
    idle_cycle();
    wait_drain();

    // Reset mid-flight discards the item.
    saved = ref_mem[30];
    send(30, lanes(5, 5, 5, 5), 1'b0, 1'b0, t);
    idle_cycle();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_wen", wen, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_ren", ren_sys_arr, 1'b0);
    sb.delete();
    ref_mem[30] = saved;
    @(negedge clk);
    #1;
    check("rst_hold_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    in_first = 1'b1;
    in_last  = 1'b0;
    in_adr   = 31;
    in_psum  = lanes(3, 3, 3, 3);
    #1;
    check("post_rst_ready", in_ready, 1'b1);
    begin
      exp_t e;
      e.adr  = 31;
      e.data = lanes(3, 3, 3, 3);
      e.last = 1'b0;
      e.cyc  = cyc;
      ref_mem[31] = e.data;
      sb.push_back(e);
    end
    idle_cycle();
    wait_drain();
    check("discarded_not_written", buf_mem[30], saved);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
